// File: rtl/regfile_writeback_buffer.sv
// Write-back FIFO between execute and the 32x32 register file, with youngest-first forwarding.
// Optional macro WB_ZERO_REG_DISCARD_EN: results for register 0 are consumed but never queued or forwarded.
module regfile_writeback_buffer #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     wb_stall,
   output logic [ADDR_W-1:0]        sel_write,
   output logic [DATA_W-1:0]        data_write,
   output logic                     write_sel,
   input  logic [ADDR_W-1:0]        sel1,
   input  logic [ADDR_W-1:0]        sel2,
   output logic                     fwd_hit1,
   output logic [DATA_W-1:0]        fwd_data1,
   output logic                     fwd_hit2,
   output logic [DATA_W-1:0]        fwd_data2,
   output logic [$clog2(DEPTH):0]   pending_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] addr_mem_r [DEPTH];
   logic [DATA_W-1:0] data_mem_r [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              accept_s;
   logic              store_s;
   logic              pop_s;

   // Handshake and FIFO control, derived from registered occupancy only.
   always_comb begin
      in_ready      = !reset && (count_r < CNT_W'(DEPTH));
      accept_s      = in_valid && in_ready;
`ifdef WB_ZERO_REG_DISCARD_EN
      store_s       = accept_s && (in_addr != {ADDR_W{1'b0}});
`else
      store_s       = accept_s;
`endif
      pop_s         = (count_r != {CNT_W{1'b0}}) && !wb_stall;
      pending_count = count_r;
   end

   // Pointer and occupancy bookkeeping; a push and pop in the same edge cancel out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (store_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({store_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (store_s) begin
         addr_mem_r[wr_ptr_r] <= in_addr;
         data_mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Register-file write port: head is presented for one cycle, address/data hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_sel  <= 1'b0;
         sel_write  <= {ADDR_W{1'b0}};
         data_write <= {DATA_W{1'b0}};
      end else if (pop_s) begin
         write_sel  <= 1'b1;
         sel_write  <= addr_mem_r[rd_ptr_r];
         data_write <= data_mem_r[rd_ptr_r];
      end else begin
         write_sel  <= 1'b0;
      end
   end

   // Forwarding search: output register first, then FIFO oldest to newest so younger matches win.
   always_comb begin : fwd_search
      logic [PTR_W-1:0] idx;
      logic             live;
      logic             m1;
      logic             m2;
      fwd_hit1  = write_sel && (sel_write == sel1);
      fwd_data1 = fwd_hit1 ? data_write : {DATA_W{1'b0}};
      fwd_hit2  = write_sel && (sel_write == sel2);
      fwd_data2 = fwd_hit2 ? data_write : {DATA_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         idx       = rd_ptr_r + PTR_W'(i);
         live      = CNT_W'(i) < count_r;
         m1        = live && (addr_mem_r[idx] == sel1);
         m2        = live && (addr_mem_r[idx] == sel2);
         fwd_hit1  = fwd_hit1 | m1;
         fwd_data1 = m1 ? data_mem_r[idx] : fwd_data1;
         fwd_hit2  = fwd_hit2 | m2;
         fwd_data2 = m2 ? data_mem_r[idx] : fwd_data2;
      end
`ifdef WB_ZERO_REG_DISCARD_EN
      fwd_hit1  = fwd_hit1 && (sel1 != {ADDR_W{1'b0}});
      fwd_data1 = (sel1 != {ADDR_W{1'b0}}) ? fwd_data1 : {DATA_W{1'b0}};
      fwd_hit2  = fwd_hit2 && (sel2 != {ADDR_W{1'b0}});
      fwd_data2 = (sel2 != {ADDR_W{1'b0}}) ? fwd_data2 : {DATA_W{1'b0}};
`endif
   end

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Self-checking bench for regfile_writeback_buffer: directed scenarios plus random traffic
// against a queue-based reference model. Honours WB_ZERO_REG_DISCARD_EN when defined.
module tb_regfile_writeback_buffer;
   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
`ifdef WB_ZERO_REG_DISCARD_EN
   localparam bit DISCARD = 1'b1;
`else
   localparam bit DISCARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          wb_stall = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic [AW-1:0] sel1 = '0;
   logic [AW-1:0] sel2 = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, write_sel, fwd_hit1, fwd_hit2;
   logic [AW-1:0] sel_write;
   logic [DW-1:0] data_write, fwd_data1, fwd_data2;
   logic [$clog2(DEPTH):0] pending_count;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;
   ent_t          q[$];
   logic          m_wsel = 1'b0;
   logic [AW-1:0] m_sel = '0;
   logic [DW-1:0] m_data = '0;

   regfile_writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
      .sel_write(sel_write), .data_write(data_write), .write_sel(write_sel),
      .sel1(sel1), .sel2(sel2), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
      .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2), .pending_count(pending_count)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      q.delete();
      m_wsel = 1'b0;
      m_sel  = '0;
      m_data = '0;
   endfunction

   // Youngest pending write wins: search output register, then queue oldest->newest overriding.
   function automatic void exp_fwd(input logic [AW-1:0] s, output logic h, output logic [DW-1:0] d);
      h = 1'b0;
      d = '0;
      if (m_wsel && m_sel == s) begin h = 1'b1; d = m_data; end
      foreach (q[i]) if (q[i].a == s) begin h = 1'b1; d = q[i].d; end
      if (DISCARD && s == '0) begin h = 1'b0; d = '0; end
   endfunction

   // Apply the model's edge behaviour for the current inputs, then advance one clock.
   task automatic cycle();
      bit acc, pp;
      acc = in_valid && !reset && (q.size() < DEPTH);
      pp  = !reset && (q.size() > 0) && !wb_stall;
      if (reset) begin
         model_reset();
      end else begin
         if (pp) begin
            m_wsel = 1'b1; m_sel = q[0].a; m_data = q[0].d;
            void'(q.pop_front());
         end else begin
            m_wsel = 1'b0;
         end
         if (acc && !(DISCARD && in_addr == '0)) q.push_back('{a: in_addr, d: in_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic enqueue(input logic [AW-1:0] a, input logic [DW-1:0] d);
      in_valid = 1'b1; in_addr = a; in_data = d;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (write_sel !== 1'b0) begin failures++; $display("FAIL reset_write_sel: got %b want 0", write_sel); end
      checks++; if (pending_count !== 3'd0) begin failures++; $display("FAIL reset_pending: got %0d want 0", pending_count); end
      checks++; if (sel_write !== 5'd0 || data_write !== 32'd0) begin failures++; $display("FAIL reset_wr_port: got %0h/%0h want 0/0", sel_write, data_write); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      wb_stall = 1'b0;
      enqueue(5'd3, 32'h11);
      checks++; if (write_sel !== 1'b0 || pending_count !== 3'd1) begin failures++; $display("FAIL single_queued: got ws=%b pc=%0d want ws=0 pc=1", write_sel, pending_count); end
      cycle();
      checks++; if (write_sel !== 1'b1 || sel_write !== 5'd3 || data_write !== 32'h11) begin failures++; $display("FAIL single_write: got ws=%b a=%0d d=%0h want 1/3/11", write_sel, sel_write, data_write); end
      cycle();
      checks++; if (write_sel !== 1'b0 || pending_count !== 3'd0) begin failures++; $display("FAIL single_idle: got ws=%b pc=%0d want 0/0", write_sel, pending_count); end
   endtask

   task automatic test_stall_fill();
      wb_stall = 1'b1;
      for (int i = 0; i < 4; i++) enqueue(AW'(i + 1), DW'(32'hA + i));
      in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hEE;
      #1;
      checks++; if (pending_count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL fill_full: got pc=%0d rdy=%b want 4/0", pending_count, in_ready); end
      cycle();
      in_valid = 1'b0;
      checks++; if (pending_count !== 3'd4) begin failures++; $display("FAIL fill_ignore5: got pc=%0d want 4", pending_count); end
      wb_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (write_sel !== 1'b1 || sel_write !== AW'(i + 1) || data_write !== DW'(32'hA + i)) begin
            failures++;
            $display("FAIL fill_order%0d: got ws=%b a=%0d d=%0h want 1/%0d/%0h", i, write_sel, sel_write, data_write, i + 1, 32'hA + i);
         end
      end
      cycle();
      checks++; if (write_sel !== 1'b0 || pending_count !== 3'd0) begin failures++; $display("FAIL fill_drained: got ws=%b pc=%0d want 0/0", write_sel, pending_count); end
   endtask

   task automatic test_forward();
      wb_stall = 1'b1;
      enqueue(5'd5, 32'h100);
      enqueue(5'd5, 32'h200);
      sel1 = 5'd5; sel2 = 5'd6;
      #1;
      checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h200) begin failures++; $display("FAIL fwd_young: got %b/%0h want 1/200", fwd_hit1, fwd_data1); end
      checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin failures++; $display("FAIL fwd_miss: got %b/%0h want 0/0", fwd_hit2, fwd_data2); end
      wb_stall = 1'b0;
      cycle();
      checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h200) begin failures++; $display("FAIL fwd_fifo_over_out: got %b/%0h want 1/200", fwd_hit1, fwd_data1); end
      cycle();
      checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h200 || pending_count !== 3'd0) begin failures++; $display("FAIL fwd_outreg: got %b/%0h pc=%0d want 1/200/0", fwd_hit1, fwd_data1, pending_count); end
      wb_stall = 1'b1;
      in_valid = 1'b1; in_addr = 5'd6; in_data = 32'h33;
      #1;
      checks++; if (fwd_hit2 !== 1'b0) begin failures++; $display("FAIL fwd_same_cycle: got %b want 0", fwd_hit2); end
      cycle();
      in_valid = 1'b0;
      checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin failures++; $display("FAIL fwd_retired: got %b/%0h want 0/0", fwd_hit1, fwd_data1); end
      checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h33) begin failures++; $display("FAIL fwd_queued: got %b/%0h want 1/33", fwd_hit2, fwd_data2); end
      wb_stall = 1'b0;
      repeat (2) cycle();
   endtask

   task automatic test_full_wrap();
      int k, w, n;
      wb_stall = 1'b1;
      for (k = 0; k < 4; k++) enqueue(AW'(8 + k), DW'(32'h1000 + k));
      wb_stall = 1'b0;
      w = 0; n = 0;
      while (w < 10 && n < 40) begin
         bit acc;
         in_valid = (k < 10); in_addr = AW'(8 + k); in_data = DW'(32'h1000 + k);
         #1;
         checks++; if (in_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL wrap_ready: got %b want %b (pc=%0d)", in_ready, q.size() < DEPTH, q.size()); end
         acc = in_valid && (q.size() < DEPTH);
         cycle();
         if (acc) k++;
         n++;
         checks++; if (write_sel !== 1'b1 && q.size() + w < 10 && w < 10 && m_wsel) begin failures++; $display("FAIL wrap_pop: got ws=%b want 1", write_sel); end
         if (write_sel === 1'b1) begin
            checks++;
            if (sel_write !== AW'(8 + w) || data_write !== DW'(32'h1000 + w)) begin
               failures++;
               $display("FAIL wrap_order%0d: got a=%0d d=%0h want %0d/%0h", w, sel_write, data_write, 8 + w, 32'h1000 + w);
            end
            w++;
         end
         checks++; if (pending_count !== q.size()) begin failures++; $display("FAIL wrap_pending: got %0d want %0d", pending_count, q.size()); end
      end
      in_valid = 1'b0;
      checks++; if (w != 10) begin failures++; $display("FAIL wrap_timeout: got %0d writes want 10", w); end
      cycle();
   endtask

   task automatic test_async_reset();
      wb_stall = 1'b1;
      for (int i = 0; i < 4; i++) enqueue(AW'(20 + i), DW'(32'h500 + i));
      wb_stall = 1'b0;
      cycle();
      checks++; if (write_sel !== 1'b1 || pending_count !== 3'd3) begin failures++; $display("FAIL areset_pre: got ws=%b pc=%0d want 1/3", write_sel, pending_count); end
      sel1 = 5'd21; sel2 = 5'd20;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++; if (write_sel !== 1'b0 || pending_count !== 3'd0) begin failures++; $display("FAIL areset_now: got ws=%b pc=%0d want 0/0", write_sel, pending_count); end
      checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL areset_fwd: got h1=%b h2=%b rdy=%b want 0/0/0", fwd_hit1, fwd_hit2, in_ready); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (write_sel !== 1'b0 || pending_count !== 3'd0) begin failures++; $display("FAIL areset_quiet%0d: got ws=%b pc=%0d want 0/0", i, write_sel, pending_count); end
      end
   endtask

   task automatic test_zero_reg();
      wb_stall = 1'b0;
      sel1 = 5'd0;
      in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFF;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL zero_ready: got %b want 1", in_ready); end
      cycle();
      in_valid = 1'b0;
`ifdef WB_ZERO_REG_DISCARD_EN
      checks++; if (pending_count !== 3'd0 || fwd_hit1 !== 1'b0) begin failures++; $display("FAIL zero_discard: got pc=%0d h1=%b want 0/0", pending_count, fwd_hit1); end
      cycle();
      checks++; if (write_sel !== 1'b0) begin failures++; $display("FAIL zero_nowrite: got ws=%b want 0", write_sel); end
`else
      checks++; if (pending_count !== 3'd1 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hFF) begin failures++; $display("FAIL zero_queued: got pc=%0d h1=%b d=%0h want 1/1/ff", pending_count, fwd_hit1, fwd_data1); end
      cycle();
      checks++; if (write_sel !== 1'b1 || sel_write !== 5'd0 || data_write !== 32'hFF) begin failures++; $display("FAIL zero_write: got ws=%b a=%0d d=%0h want 1/0/ff", write_sel, sel_write, data_write); end
`endif
      cycle();
   endtask

   task automatic test_random();
      logic          h1, h2;
      logic [DW-1:0] d1, d2;
      for (int n = 0; n < 300; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         wb_stall = ($urandom_range(0, 2) == 0);
         in_addr  = AW'($urandom_range(0, 7));
         in_data  = $urandom;
         sel1     = AW'($urandom_range(0, 7));
         sel2     = AW'($urandom_range(0, 7));
         #1;
         checks++; if (in_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready@%0d: got %b want %b", n, in_ready, q.size() < DEPTH); end
         cycle();
         checks++;
         if (write_sel !== m_wsel || sel_write !== m_sel || data_write !== m_data) begin
            failures++;
            $display("FAIL rnd_write@%0d: got %b/%0d/%0h want %b/%0d/%0h", n, write_sel, sel_write, data_write, m_wsel, m_sel, m_data);
         end
         checks++; if (pending_count !== q.size()) begin failures++; $display("FAIL rnd_pending@%0d: got %0d want %0d", n, pending_count, q.size()); end
         exp_fwd(sel1, h1, d1);
         exp_fwd(sel2, h2, d2);
         checks++; if (fwd_hit1 !== h1 || fwd_data1 !== d1) begin failures++; $display("FAIL rnd_fwd1@%0d: got %b/%0h want %b/%0h", n, fwd_hit1, fwd_data1, h1, d1); end
         checks++; if (fwd_hit2 !== h2 || fwd_data2 !== d2) begin failures++; $display("FAIL rnd_fwd2@%0d: got %b/%0h want %b/%0h", n, fwd_hit2, fwd_data2, h2, d2); end
      end
      in_valid = 1'b0;
      wb_stall = 1'b0;
      repeat (DEPTH + 2) cycle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall_fill();
      test_forward();
      test_full_wrap();
      test_async_reset();
      test_zero_reg();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion want finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
